pc_fetch_sequencer: RTL and testbench

Drives the program counter into the single-cycle CPU datapath and sequences instruction fetch from instruction memory over a req/ack handshake. It presents each fetched instruction to the CPU and samples the CPU's Branch, Zero and ShiftLeftImm outputs for that instruction. It then computes the next PC, replacing the hand-stepped PC stimulus with a self-running fetch loop. It sits between instruction memory and the CPU's PC/instruction inputs.

---
 rtl/pc_fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Self-running instruction fetch loop: drives PC, fetches over a req/ack handshake and computes the next PC.
// Optional retired/taken-branch counters are built when FETCH_STATS_EN is defined.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          MAX_WAIT   = 15,
    parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Run,
    input  logic        Stall,
    output logic        InstrReq,
    input  logic        InstrAck,
    input  logic [31:0] InstrData,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        InstrValid,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] ShiftLeftImm,
    output logic        Halted,
    output logic        Timeout,
    output logic [31:0] InstrCount,
    output logic [31:0] BranchCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    // The wait counter holds the number of WAIT cycles already spent, so the last permitted one sees MAX_WAIT-1.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_waitCnt;

    logic        w_taken;
    logic        w_retire;
    logic        w_isHalt;
    logic [31:0] w_pcSum;
    logic [31:0] w_pcNext;

    assign w_taken  = Branch & Zero;
    assign w_retire = (r_state == S_EXEC) && !Stall;
    assign w_isHalt = (r_instr == HALT_INSTR);
    assign w_pcSum  = r_pc + 32'd4 + (w_taken ? ShiftLeftImm : 32'd0);
    assign w_pcNext = w_pcSum & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        InstrReq    = 1'b0;
        InstrValid  = 1'b0;
        Halted      = 1'b0;
        Timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Run) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                InstrReq    = 1'b1;
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (InstrAck) begin
                    w_nextState = S_EXEC;
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = S_ERROR;
                end
            end
            S_EXEC: begin
                InstrValid = 1'b1;
                if (!Stall) begin
                    if (w_isHalt) begin
                        w_nextState = S_HALT;
                    end else if (Run) begin
                        w_nextState = S_REQ;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            S_ERROR: begin
                Timeout = 1'b1;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // PC, latched instruction and wait counter; a halt exit leaves PC on the halting instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_waitCnt <= 8'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    r_waitCnt <= 8'd0;
                end
                S_WAIT: begin
                    if (InstrAck) begin
                        r_instr <= InstrData;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (w_retire && !w_isHalt) begin
                        r_pc <= w_pcNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign PC          = r_pc;
    assign instruction = r_instr;

`ifdef FETCH_STATS_EN
    logic [31:0] r_instrCount;
    logic [31:0] r_branchCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instrCount  <= 32'd0;
            r_branchCount <= 32'd0;
        end else if (w_retire) begin
            r_instrCount <= r_instrCount + 32'd1;
            if (w_taken) begin
                r_branchCount <= r_branchCount + 32'd1;
            end
        end
    end

    assign InstrCount  = r_instrCount;
    assign BranchCount = r_branchCount;
`else
    assign InstrCount  = 32'd0;
    assign BranchCount = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a cycle model of the fetch rules is compared every cycle,
// and literal expectations pin fetch addresses, timing, stall, timeout, halt and reset behaviour.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC  = 32'd0;
    localparam logic [31:0] RST_PC2 = 32'hFFFFFFFC;
    localparam int          MAXW    = 15;
    localparam logic [31:0] HALTW   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Run = 1'b0;
    logic        Stall = 1'b0;
    logic        InstrAck = 1'b0;
    logic [31:0] InstrData = 32'd0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] ShiftLeftImm = 32'd0;

    logic        InstrReq, InstrValid, Halted, Timeout;
    logic [31:0] PC, instruction, InstrCount, BranchCount;
    logic        InstrReq2, InstrValid2, Halted2, Timeout2;
    logic [31:0] PC2, instruction2, InstrCount2, BranchCount2;

    pc_fetch_sequencer #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW), .HALT_INSTR(HALTW)) dut (
        .clk(clk), .reset(reset), .Run(Run), .Stall(Stall),
        .InstrReq(InstrReq), .InstrAck(InstrAck), .InstrData(InstrData),
        .PC(PC), .instruction(instruction), .InstrValid(InstrValid),
        .Branch(Branch), .Zero(Zero), .ShiftLeftImm(ShiftLeftImm),
        .Halted(Halted), .Timeout(Timeout),
        .InstrCount(InstrCount), .BranchCount(BranchCount)
    );

    pc_fetch_sequencer #(.RESET_PC(RST_PC2), .MAX_WAIT(MAXW), .HALT_INSTR(HALTW)) dut2 (
        .clk(clk), .reset(reset), .Run(Run), .Stall(Stall),
        .InstrReq(InstrReq2), .InstrAck(InstrAck), .InstrData(InstrData),
        .PC(PC2), .instruction(instruction2), .InstrValid(InstrValid2),
        .Branch(Branch), .Zero(Zero), .ShiftLeftImm(ShiftLeftImm),
        .Halted(Halted2), .Timeout(Timeout2),
        .InstrCount(InstrCount2), .BranchCount(BranchCount2)
    );

    initial forever #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    bit checking = 1'b0;
    int cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic stall, input logic br,
                                 input logic zr, input logic [31:0] imm);
        Run = run;
        Stall = stall;
        Branch = br;
        Zero = zr;
        ShiftLeftImm = imm;
    endtask

    // Instruction memory contents: a distinct non-halt word per address, plus an optional halt word.
    bit          haltEn = 1'b0;
    logic [31:0] haltAddr = 32'd0;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (haltEn && addr == haltAddr) return HALTW;
        return 32'h0040_0013 ^ addr;
    endfunction

    // Memory responder: ack arrives ackDelay cycles after the request cycle.
    int          ackDelay = 1;
    bit          ackOff = 1'b0;
    bit          strayAck = 1'b0;
    int          pend = -1;
    logic [31:0] reqAddr = 32'd0;

    initial forever begin
        @(negedge clk);
        InstrAck = 1'b0;
        if (pend > 0) pend--;
        if (pend == 0) begin
            InstrAck = 1'b1;
            InstrData = memWord(reqAddr);
            pend = -1;
        end
        if (strayAck) begin
            InstrAck = 1'b1;
            InstrData = 32'hDEADBEEF;
        end
        if (InstrReq === 1'b1 && !ackOff) begin
            reqAddr = PC;
            pend = ackDelay;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [31:0] reqPC[$];
    int          reqCyc[$];
    logic [31:0] req2PC[$];

    initial forever begin
        @(negedge clk);
        if (InstrReq === 1'b1) begin
            reqPC.push_back(PC);
            reqCyc.push_back(cyc);
        end
        if (InstrReq2 === 1'b1) req2PC.push_back(PC2);
    end

    // Reference model of the fetch rules, advanced on the same edge as the design.
    typedef enum {P_IDLE, P_REQ, P_WAIT, P_EXEC, P_HALT, P_ERR} phase_t;
    phase_t      mPhase = P_IDLE;
    logic [31:0] mPC = RST_PC;
    logic [31:0] mInstr = 32'd0;
    logic [31:0] mIcnt = 32'd0;
    logic [31:0] mBcnt = 32'd0;
    int          mWaits = 0;

    always @(posedge clk) begin
        if (reset) begin
            mPhase <= P_IDLE;
            mPC    <= RST_PC;
            mInstr <= 32'd0;
            mIcnt  <= 32'd0;
            mBcnt  <= 32'd0;
            mWaits <= 0;
        end else begin
            case (mPhase)
                P_IDLE: if (Run) mPhase <= P_REQ;
                P_REQ: begin
                    mWaits <= 0;
                    mPhase <= P_WAIT;
                end
                P_WAIT: begin
                    if (InstrAck) begin
                        mInstr <= InstrData;
                        mPhase <= P_EXEC;
                    end else begin
                        mWaits <= mWaits + 1;
                        if (mWaits + 1 >= MAXW) mPhase <= P_ERR;
                    end
                end
                P_EXEC: begin
                    if (!Stall) begin
                        mIcnt <= mIcnt + 32'd1;
                        if (Branch && Zero) mBcnt <= mBcnt + 32'd1;
                        if (mInstr == HALTW) begin
                            mPhase <= P_HALT;
                        end else begin
                            mPC <= (mPC + 32'd4 + ((Branch && Zero) ? ShiftLeftImm : 32'd0)) & 32'hFFFF_FFFC;
                            mPhase <= Run ? P_REQ : P_IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            checkOutput("PC", PC, mPC);
            checkOutput("instruction", instruction, mInstr);
            checkOutput("InstrReq", {31'd0, InstrReq}, {31'd0, mPhase == P_REQ});
            checkOutput("InstrValid", {31'd0, InstrValid}, {31'd0, mPhase == P_EXEC});
            checkOutput("Halted", {31'd0, Halted}, {31'd0, mPhase == P_HALT});
            checkOutput("Timeout", {31'd0, Timeout}, {31'd0, mPhase == P_ERR});
`ifdef FETCH_STATS_EN
            checkOutput("InstrCount", InstrCount, mIcnt);
            checkOutput("BranchCount", BranchCount, mBcnt);
`else
            checkOutput("InstrCount", InstrCount, 32'd0);
            checkOutput("BranchCount", BranchCount, 32'd0);
`endif
        end
    end

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitExecAt(input logic [31:0] addr, input string name);
        int n = 0;
        while (!(InstrValid === 1'b1 && PC == addr) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vecs++;
            errs++;
            $display("[TB] FAIL %s: no EXEC at PC %h within 200 cycles", name, addr);
        end
    endtask

    task automatic waitReqCount(input int target, input int budget, input string name);
        int n = 0;
        while (reqPC.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (reqPC.size() < target) begin
            vecs++;
            errs++;
            $display("[TB] FAIL %s: %0d requests seen, needed %0d", name, reqPC.size(), target);
        end
    endtask

    initial begin
        int c0, n, validCycles;
        logic [31:0] ic0;

        repeat (2) @(negedge clk);
        checking = 1'b1;
        reset = 1'b0;

        // Reset values and plain sequential fetch, including wrap of the second instance.
        doReset();
        checkOutput("rst PC", PC, 32'd0);
        checkOutput("rst instruction", instruction, 32'd0);
        checkOutput("rst InstrReq", {31'd0, InstrReq}, 32'd0);
        checkOutput("rst InstrValid", {31'd0, InstrValid}, 32'd0);
        checkOutput("rst Halted", {31'd0, Halted}, 32'd0);
        checkOutput("rst Timeout", {31'd0, Timeout}, 32'd0);
        checkOutput("rst counts", InstrCount | BranchCount, 32'd0);
        checkOutput("rst PC2", PC2, 32'hFFFFFFFC);
        checkOutput("rst2 flags", {27'd0, InstrReq2, InstrValid2, Halted2, Timeout2, 1'b0}, 32'd0);
        checkOutput("rst2 regs", instruction2 | InstrCount2 | BranchCount2, 32'd0);
        reqPC.delete();
        reqCyc.delete();
        req2PC.delete();
        c0 = cyc;
        Run = 1'b1;
        waitReqCount(4, 60, "seq fetch");
        if (reqPC.size() >= 4) begin
            checkOutput("first req cycle", 32'(reqCyc[0]), 32'(c0 + 1));
            for (int i = 0; i < 4; i++) checkOutput("seq req PC", reqPC[i], 32'(4 * i));
            for (int i = 0; i < 3; i++) checkOutput("req spacing", 32'(reqCyc[i + 1] - reqCyc[i]), 32'd3);
        end
        if (req2PC.size() >= 2) begin
            checkOutput("wrap req0 PC2", req2PC[0], 32'hFFFFFFFC);
            checkOutput("wrap req1 PC2", req2PC[1], 32'd0);
        end else begin
            checkOutput("wrap req count", 32'(req2PC.size()), 32'd2);
        end

        // Taken branch back to 4, then not-taken branch falls through to 12.
        doReset();
        Run = 1'b1;
        waitExecAt(32'd8, "branch exec");
        n = reqPC.size();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        waitReqCount(n + 1, 10, "taken req");
        if (reqPC.size() > n) checkOutput("taken target", reqPC[n], 32'd4);
`ifdef FETCH_STATS_EN
        checkOutput("BranchCount taken", BranchCount, 32'd1);
`endif
        waitExecAt(32'd8, "not-taken exec");
        n = reqPC.size();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF8);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        waitReqCount(n + 1, 10, "not-taken req");
        if (reqPC.size() > n) checkOutput("not-taken target", reqPC[n], 32'd12);

        // Run dropped in EXEC: finish this instruction then idle.
        waitExecAt(32'd12, "stop exec");
        Run = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idle PC", PC, 32'd16);
        checkOutput("idle InstrReq", {31'd0, InstrReq}, 32'd0);

        // Four-cycle stall at PC 4 with a stray ack.
        doReset();
        Run = 1'b1;
        waitExecAt(32'd4, "stall exec");
        ic0 = InstrCount;
        Stall = 1'b1;
        strayAck = 1'b1;
        validCycles = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (InstrValid === 1'b1) validCycles++;
            checkOutput("stall PC", PC, 32'd4);
        end
        Stall = 1'b0;
        strayAck = 1'b0;
        checkOutput("stall instruction", instruction, memWord(32'd4));
        @(negedge clk);
        checkOutput("stall valid cycles", 32'(validCycles), 32'd5);
        checkOutput("post-stall InstrValid", {31'd0, InstrValid}, 32'd0);
`ifdef FETCH_STATS_EN
        checkOutput("stall InstrCount", InstrCount, ic0 + 32'd1);
`else
        checkOutput("stall InstrCount", InstrCount, 32'd0);
`endif

        // Memory never acks: ERROR after MAX_WAIT WAIT cycles.
        doReset();
        ackOff = 1'b1;
        Run = 1'b1;
        n = 0;
        while (InstrReq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) checkOutput("timeout early", {31'd0, Timeout}, 32'd0);
            if (k == 16) checkOutput("timeout set", {31'd0, Timeout}, 32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("error no req", {31'd0, InstrReq}, 32'd0);
        end
        ackOff = 1'b0;

        // Ack in the last permitted WAIT cycle is accepted.
        doReset();
        ackDelay = 15;
        Run = 1'b1;
        n = 0;
        while (InstrReq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (16) @(negedge clk);
        checkOutput("late ack valid", {31'd0, InstrValid}, 32'd1);
        checkOutput("late ack no timeout", {31'd0, Timeout}, 32'd0);
        checkOutput("late ack instruction", instruction, memWord(32'd0));
        ackDelay = 1;

        // Halt word at PC 12.
        doReset();
        haltEn = 1'b1;
        haltAddr = 32'd12;
        Run = 1'b1;
        n = 0;
        while (Halted !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halted", {31'd0, Halted}, 32'd1);
        checkOutput("halt PC", PC, 32'd12);
`ifdef FETCH_STATS_EN
        checkOutput("halt InstrCount", InstrCount, 32'd4);
`endif
        n = reqPC.size();
        repeat (10) @(negedge clk);
        checkOutput("halt no req", 32'(reqPC.size()), 32'(n));
        doReset();
        haltEn = 1'b0;
        checkOutput("post-halt PC", PC, 32'd0);
        checkOutput("post-halt Halted", {31'd0, Halted}, 32'd0);

        // Reset in WAIT with the ack landing right after it.
        ackDelay = 2;
        Run = 1'b1;
        n = 0;
        while (InstrReq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        reset = 1'b1;
        Run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midwait instruction", instruction, 32'd0);
        checkOutput("midwait InstrValid", {31'd0, InstrValid}, 32'd0);
        checkOutput("midwait InstrReq", {31'd0, InstrReq}, 32'd0);
        checkOutput("midwait PC", PC, 32'd0);
        ackDelay = 1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
